// File: rtl/dispatch_ctrl.sv
// ============================================================================
// Module   : dispatch_ctrl
// Purpose  : In-order dispatch FIFO that steers decoded micro-ops to the ALU,
//            LSU or branch issue queue, with optional branch serialisation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dispatch_ctrl #(
   parameter int DEPTH        = 2,
   parameter int BR_SERIALIZE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        dec_valid,
   output logic        dec_ready,
   input  logic [31:0] dec_pc,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   input  logic [31:0] dec_imm,
   input  logic [2:0]  dec_aluop,
   input  logic [6:0]  dec_opcode,
   output logic [31:0] disp_pc,
   output logic [4:0]  disp_rs1,
   output logic [4:0]  disp_rs2,
   output logic [4:0]  disp_rd,
   output logic [31:0] disp_imm,
   output logic [2:0]  disp_aluop,
   output logic        alu_valid,
   input  logic        alu_ready,
   output logic        lsu_valid,
   input  logic        lsu_ready,
   output logic        br_valid,
   input  logic        br_ready,
   input  logic        br_resolve,
   output logic        illegal,
   output logic [15:0] stall_cnt
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
   localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_BR_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      CL_ALU = 2'd0,
      CL_LSU = 2'd1,
      CL_BR  = 2'd2,
      CL_ILL = 2'd3
   } class_t;

   logic [31:0]        r_pc_mem    [DEPTH];
   logic [4:0]         r_rs1_mem   [DEPTH];
   logic [4:0]         r_rs2_mem   [DEPTH];
   logic [4:0]         r_rd_mem    [DEPTH];
   logic [31:0]        r_imm_mem   [DEPTH];
   logic [2:0]         r_aluop_mem [DEPTH];
   logic [6:0]         r_op_mem    [DEPTH];

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   state_t             r_state;
   logic [15:0]        r_stall_cnt;

   logic               w_head_valid;
   logic               w_offer;
   class_t             w_class;
   logic               w_push;
   logic               w_pop;
   logic               w_br_pop;
   logic               w_serialize;

   generate
      if (BR_SERIALIZE != 0) begin : g_br_serialize
         assign w_serialize = 1'b1;
      end else begin : g_br_no_serialize
         assign w_serialize = 1'b0;
      end
   endgenerate

   assign w_head_valid = (r_count != '0);

   always_comb begin
      w_class = CL_ILL;
      case (r_op_mem[r_rd_ptr])
         7'b0010011, 7'b0110011, 7'b0110111: w_class = CL_ALU;
         7'b0000011, 7'b0100011:             w_class = CL_LSU;
         7'b1100011, 7'b1100111:             w_class = CL_BR;
         default:                            w_class = CL_ILL;
      endcase
   end

   // Only one class matches, so at most one valid (or illegal) is raised.
   assign w_offer   = w_head_valid && (r_state == ST_RUN) && !flush;
   assign alu_valid = w_offer && (w_class == CL_ALU);
   assign lsu_valid = w_offer && (w_class == CL_LSU);
   assign br_valid  = w_offer && (w_class == CL_BR);
   assign illegal   = w_offer && (w_class == CL_ILL);

   assign w_br_pop = br_valid && br_ready;
   assign w_pop    = (alu_valid && alu_ready) || (lsu_valid && lsu_ready) ||
                     w_br_pop || illegal;

   // No pop look-ahead: a full FIFO refuses input even while it drains.
   assign dec_ready = (r_count < c_DEPTH_CNT) && reset;
   assign w_push    = dec_valid && dec_ready && !flush;

   always_comb begin
      disp_pc    = '0;
      disp_rs1   = '0;
      disp_rs2   = '0;
      disp_rd    = '0;
      disp_imm   = '0;
      disp_aluop = '0;
      if (w_head_valid) begin
         disp_pc    = r_pc_mem[r_rd_ptr];
         disp_rs1   = r_rs1_mem[r_rd_ptr];
         disp_rs2   = r_rs2_mem[r_rd_ptr];
         disp_rd    = r_rd_mem[r_rd_ptr];
         disp_imm   = r_imm_mem[r_rd_ptr];
         disp_aluop = r_aluop_mem[r_rd_ptr];
      end
   end

   assign stall_cnt = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= dec_pc;
         r_rs1_mem[r_wr_ptr]   <= dec_rs1;
         r_rs2_mem[r_wr_ptr]   <= dec_rs2;
         r_rd_mem[r_wr_ptr]    <= dec_rd;
         r_imm_mem[r_wr_ptr]   <= dec_imm;
         r_aluop_mem[r_wr_ptr] <= dec_aluop;
         r_op_mem[r_wr_ptr]    <= dec_opcode;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_state     <= ST_RUN;
         r_stall_cnt <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= ST_RUN;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

         case (r_state)
            ST_RUN: begin
               if (w_br_pop && w_serialize) begin
                  r_state <= ST_BR_WAIT;
               end
            end
            ST_BR_WAIT: begin
               if (br_resolve) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase

         if (w_head_valid && !w_pop && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
// ============================================================================
// Module   : tb_dispatch_ctrl
// Purpose  : Directed self-checking bench for dispatch_ctrl (DEPTH=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dispatch_ctrl;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic [31:0] dec_imm;
   logic [2:0]  dec_aluop;
   logic [6:0]  dec_opcode;
   logic [31:0] disp_pc;
   logic [4:0]  disp_rs1;
   logic [4:0]  disp_rs2;
   logic [4:0]  disp_rd;
   logic [31:0] disp_imm;
   logic [2:0]  disp_aluop;
   logic        alu_valid;
   logic        alu_ready;
   logic        lsu_valid;
   logic        lsu_ready;
   logic        br_valid;
   logic        br_ready;
   logic        br_resolve;
   logic        illegal;
   logic [15:0] stall_cnt;

   int n_checks;
   int n_fail;

   localparam logic [6:0] c_OP_ADDI  = 7'b0010011;
   localparam logic [6:0] c_OP_ADD   = 7'b0110011;
   localparam logic [6:0] c_OP_LW    = 7'b0000011;
   localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
   localparam logic [6:0] c_OP_FENCE = 7'b0001111;

   dispatch_ctrl #(
      .DEPTH        (2),
      .BR_SERIALIZE (1)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .dec_pc     (dec_pc),
      .dec_rs1    (dec_rs1),
      .dec_rs2    (dec_rs2),
      .dec_rd     (dec_rd),
      .dec_imm    (dec_imm),
      .dec_aluop  (dec_aluop),
      .dec_opcode (dec_opcode),
      .disp_pc    (disp_pc),
      .disp_rs1   (disp_rs1),
      .disp_rs2   (disp_rs2),
      .disp_rd    (disp_rd),
      .disp_imm   (disp_imm),
      .disp_aluop (disp_aluop),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .br_valid   (br_valid),
      .br_ready   (br_ready),
      .br_resolve (br_resolve),
      .illegal    (illegal),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_uop(input logic [6:0] op, input logic [31:0] pc);
      dec_valid  = 1'b1;
      dec_opcode = op;
      dec_pc     = pc;
      dec_imm    = pc + 32'h1000;
      dec_rs1    = pc[6:2];
      dec_rs2    = 5'd2;
      dec_rd     = 5'd3;
      dec_aluop  = 3'd5;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b0;
      flush      = 1'b0;
      dec_valid  = 1'b0;
      dec_pc     = '0;
      dec_rs1    = '0;
      dec_rs2    = '0;
      dec_rd     = '0;
      dec_imm    = '0;
      dec_aluop  = '0;
      dec_opcode = '0;
      alu_ready  = 1'b0;
      lsu_ready  = 1'b0;
      br_ready   = 1'b0;
      br_resolve = 1'b0;

      // Reset state
      step();
      step();
      check("rst_dec_ready", 32'(dec_ready), 32'd0);
      check("rst_valids", {29'd0, alu_valid, lsu_valid, br_valid}, 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_disp_pc", disp_pc, 32'd0);
      reset = 1'b1;
      settle();
      check("rst_release_ready", 32'(dec_ready), 32'd1);

      // Single ALU op: no bypass, offered one cycle after the push
      alu_ready = 1'b1;
      drive_uop(c_OP_ADDI, 32'h100);
      settle();
      check("alu_nobypass", 32'(alu_valid), 32'd0);
      step();
      dec_valid = 1'b0;
      settle();
      check("alu_valid", 32'(alu_valid), 32'd1);
      check("alu_disp_pc", disp_pc, 32'h100);
      check("alu_disp_imm", disp_imm, 32'h1100);
      check("alu_others", {30'd0, lsu_valid, br_valid}, 32'd0);
      step();
      check("alu_drained", 32'(alu_valid), 32'd0);
      check("alu_stall", 32'(stall_cnt), 32'd0);

      // LSU fill, backpressure and in-order drain
      alu_ready = 1'b0;
      drive_uop(c_OP_LW, 32'h200);
      step();
      drive_uop(c_OP_LW, 32'h204);
      step();
      drive_uop(c_OP_LW, 32'h208);
      settle();
      check("lsu_full_ready", 32'(dec_ready), 32'd0);
      check("lsu_stall1", 32'(stall_cnt), 32'd1);
      check("lsu_valid", 32'(lsu_valid), 32'd1);
      check("lsu_head0", disp_pc, 32'h200);
      step();
      step();
      step();
      check("lsu_stall4", 32'(stall_cnt), 32'd4);
      check("lsu_still_full", 32'(dec_ready), 32'd0);
      lsu_ready = 1'b1;
      settle();
      check("lsu_drain0", disp_pc, 32'h200);
      step();
      check("lsu_drain1", disp_pc, 32'h204);
      check("lsu_ready_again", 32'(dec_ready), 32'd1);
      step();
      dec_valid = 1'b0;
      check("lsu_drain2", disp_pc, 32'h208);
      check("lsu_pushpop_valid", 32'(lsu_valid), 32'd1);
      step();
      check("lsu_empty", 32'(lsu_valid), 32'd0);
      check("lsu_empty_pc", disp_pc, 32'd0);
      check("lsu_stall_hold", 32'(stall_cnt), 32'd4);
      lsu_ready = 1'b0;

      // Branch serialisation
      drive_uop(c_OP_BEQ, 32'h300);
      step();
      drive_uop(c_OP_ADD, 32'h304);
      step();
      dec_valid = 1'b0;
      br_ready  = 1'b1;
      alu_ready = 1'b1;
      settle();
      check("br_valid", 32'(br_valid), 32'd1);
      check("br_alu_blocked", 32'(alu_valid), 32'd0);
      check("br_stall5", 32'(stall_cnt), 32'd5);
      step();
      for (int i = 0; i < 5; i++) begin
         check("br_wait_alu", 32'(alu_valid), 32'd0);
         check("br_wait_br", 32'(br_valid), 32'd0);
         step();
      end
      br_resolve = 1'b1;
      settle();
      check("br_resolve_cycle", 32'(alu_valid), 32'd0);
      step();
      br_resolve = 1'b0;
      settle();
      check("br_after_resolve", 32'(alu_valid), 32'd1);
      check("br_after_pc", disp_pc, 32'h304);
      check("br_stall11", 32'(stall_cnt), 32'd11);
      step();

      // Illegal opcode drop followed by a legal op
      drive_uop(c_OP_FENCE, 32'h400);
      step();
      drive_uop(c_OP_ADDI, 32'h404);
      settle();
      check("ill_pulse", 32'(illegal), 32'd1);
      check("ill_no_valid", {29'd0, alu_valid, lsu_valid, br_valid}, 32'd0);
      check("ill_pc", disp_pc, 32'h400);
      step();
      dec_valid = 1'b0;
      settle();
      check("ill_cleared", 32'(illegal), 32'd0);
      check("ill_next_valid", 32'(alu_valid), 32'd1);
      check("ill_next_pc", disp_pc, 32'h404);
      step();
      check("ill_stall", 32'(stall_cnt), 32'd11);

      // Flush while full and waiting on a branch
      alu_ready = 1'b0;
      drive_uop(c_OP_BEQ, 32'h500);
      step();
      drive_uop(c_OP_ADD, 32'h504);
      step();
      drive_uop(c_OP_ADD, 32'h508);
      step();
      check("fl_full", 32'(dec_ready), 32'd0);
      check("fl_stall12", 32'(stall_cnt), 32'd12);
      drive_uop(c_OP_ADD, 32'h50C);
      alu_ready  = 1'b1;
      br_resolve = 1'b1;
      flush      = 1'b1;
      settle();
      check("fl_cycle_valids", {28'd0, alu_valid, lsu_valid, br_valid, illegal}, 32'd0);
      step();
      flush      = 1'b0;
      br_resolve = 1'b0;
      dec_valid  = 1'b0;
      settle();
      check("fl_empty_ready", 32'(dec_ready), 32'd1);
      check("fl_no_valid", 32'(alu_valid), 32'd0);
      check("fl_empty_pc", disp_pc, 32'd0);
      check("fl_stall_kept", 32'(stall_cnt), 32'd12);
      drive_uop(c_OP_ADDI, 32'h600);
      step();
      dec_valid = 1'b0;
      settle();
      check("fl_state_run", 32'(alu_valid), 32'd1);
      check("fl_new_pc", disp_pc, 32'h600);
      step();

      // Reset in the middle of traffic
      alu_ready = 1'b0;
      br_ready  = 1'b0;
      drive_uop(c_OP_ADD, 32'h700);
      step();
      drive_uop(c_OP_ADD, 32'h704);
      step();
      dec_valid = 1'b0;
      check("mr_stall13", 32'(stall_cnt), 32'd13);
      reset = 1'b0;
      step();
      check("mr_dec_ready", 32'(dec_ready), 32'd0);
      check("mr_valids", {28'd0, alu_valid, lsu_valid, br_valid, illegal}, 32'd0);
      check("mr_disp_pc", disp_pc, 32'd0);
      check("mr_stall", 32'(stall_cnt), 32'd0);
      reset = 1'b1;
      settle();
      check("mr_release", 32'(dec_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
